// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the rotating-priority pick function for the four-way
// round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  // The scan runs from the farthest offset down to the nearest one, so the
  // last hit is the first valid index at or after ptr.
  function automatic req_idx_t rot_pick(input req_idx_t ptr, input logic [N_REQ-1:0] valid);
    req_idx_t idx;
    req_idx_t res;
    res = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + req_idx_t'(k);
      if (valid[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 data multiplexer driven by a 2-bit select.
module mux_4_1 #(
  parameter int W = 4
) (
  input  logic [1:0]   i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  output logic [W-1:0] o_y
);

  // Select one of four words
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      2'd3:    o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module rr_pick_4
  import rr_mux_arbiter_pkg::*;
(
  input  req_idx_t         i_ptr,
  input  logic [N_REQ-1:0] i_valid,
  output req_idx_t         o_grant,
  output logic             o_any_req
);

  assign o_grant   = rot_pick(i_ptr, i_valid);
  assign o_any_req = |i_valid;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter feeding a shared 4:1 mux into a
// one-entry output register with full throughput and backpressure.
module rr_mux_arbiter_4
  import rr_mux_arbiter_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [W-1:0]     in_data0,
  input  logic [W-1:0]     in_data1,
  input  logic [W-1:0]     in_data2,
  input  logic [W-1:0]     in_data3,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  req_idx_t         r_ptr;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  req_idx_t         r_out_src;

  req_idx_t         w_grant;
  logic             w_any_req;
  logic             w_load_en;
  logic [W-1:0]     w_mux_data;
  logic [N_REQ-1:0] w_in_ready;

  rr_pick_4 u_pick (
    .i_ptr     (r_ptr),
    .i_valid   (in_valid),
    .o_grant   (w_grant),
    .o_any_req (w_any_req)
  );

  mux_4_1 #(.W(W)) u_mux (
    .i_sel (w_grant),
    .i_d0  (in_data0),
    .i_d1  (in_data1),
    .i_d2  (in_data2),
    .i_d3  (in_data3),
    .o_y   (w_mux_data)
  );

  // out_ready reaches in_ready combinationally so a drain and a load share one edge
  assign w_load_en = ~r_out_valid | out_ready;

  // One-hot ready toward the granted requester
  always_comb begin
    w_in_ready = 4'b0000;
    if (w_load_en && w_any_req) begin
      w_in_ready = 4'b0001 << w_grant;
    end else begin
      w_in_ready = 4'b0000;
    end
  end

  // Output register and rotating priority pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= {W{1'b0}};
      r_out_src   <= 2'd0;
    end else if (w_load_en) begin
      if (w_any_req) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_src   <= w_grant;
        r_ptr       <= w_grant + 2'd1;
      end else begin
        r_out_valid <= 1'b0;
        r_out_data  <= r_out_data;
        r_out_src   <= r_out_src;
        r_ptr       <= r_ptr;
      end
    end else begin
      r_ptr       <= r_ptr;
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
      r_out_src   <= r_out_src;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
